// File: rtl/calc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : calc_pkg                                                     |
// | Description : Shared sizes, NOP word and program-store state encoding for  |
// |               the calculator core and its program store.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package calc_pkg;

    localparam int CALC_IW    = 11;
    localparam int CALC_AW    = 4;
    localparam int CALC_DEPTH = 16;

    localparam logic [CALC_IW-1:0] CALC_NOP = 11'h000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } prog_state_t;

endpackage : calc_pkg
`default_nettype wire

// File: rtl/calc_prog_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : calc_prog_ram                                                |
// | Description : DEPTH x IW program memory, synchronous write and synchronous |
// |               read, shaped to infer a block RAM. No reset on the array or  |
// |               the read register so the RAM primitive can absorb both.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module calc_prog_ram #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int IW    = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem [DEPTH];
    logic [IW-1:0] rdata_q;

    // Write port and registered read port share one clock edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;

endmodule : calc_prog_ram
`default_nettype wire

// File: rtl/calc_prog_store.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : calc_prog_store                                              |
// | Description : Program store and instruction feeder. Loads up to DEPTH     |
// |               words over a valid/ready port, then serves pc -> inst_w with |
// |               one cycle of latency while in RUN. Addresses at or beyond    |
// |               prog_len, and any fetch outside RUN, return NOP_WORD.        |
// |               Optional macro CALC_PROG_CHECKSUM_EN adds prog_sum, the      |
// |               running XOR of accepted words.                               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module calc_prog_store
    import calc_pkg::*;
#(
    parameter int            DEPTH    = CALC_DEPTH,
    parameter int            AW       = CALC_AW,
    parameter int            IW       = CALC_IW,
    parameter logic [IW-1:0] NOP_WORD = CALC_NOP
) (
    input  logic          CLOCK_50,
    input  logic          reset_n,
    input  logic          load_start,
    input  logic          load_valid,
    input  logic [IW-1:0] load_data,
    input  logic          load_last,
    output logic          load_ready,
    input  logic [AW-1:0] pc,
    output logic [IW-1:0] inst_w,
    output logic          run,
    output logic [AW:0]   prog_len,
`ifdef CALC_PROG_CHECKSUM_EN
    output logic [IW-1:0] prog_sum,
`endif
    output logic          load_err
);

    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    prog_state_t   state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   prog_len_q, prog_len_d;
    logic          load_err_q, load_err_d;
    logic          fetch_ok_q, fetch_ok_d;
    logic          accept;
    logic [IW-1:0] ram_rdata;

    // Next-state, write-pointer, length, error and fetch-mask logic.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        prog_len_d = prog_len_q;
        load_err_d = load_err_q;
        accept     = 1'b0;

        if (load_start) begin
            // Start wins over a same-cycle word; that word is silently discarded.
            state_d    = LOAD;
            wr_ptr_d   = '0;
            prog_len_d = '0;
        end else if (load_valid) begin
            if (state_q == LOAD) begin
                accept     = 1'b1;
                wr_ptr_d   = wr_ptr_q + 1'b1;
                prog_len_d = prog_len_q + 1'b1;
                if (load_last || (wr_ptr_q == LAST_PTR)) begin
                    state_d = RUN;
                end
            end else begin
                load_err_d = 1'b1;
            end
        end

        // Masking the start edge here makes inst_w go NOP on that same edge.
        fetch_ok_d = (state_q == RUN) && !load_start && ({1'b0, pc} < prog_len_q);
    end

    // State and control registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            prog_len_q <= '0;
            load_err_q <= 1'b0;
            fetch_ok_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            prog_len_q <= prog_len_d;
            load_err_q <= load_err_d;
            fetch_ok_q <= fetch_ok_d;
        end
    end

    calc_prog_ram #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .IW    (IW)
    ) u_ram (
        .clk   (CLOCK_50),
        .we    (accept),
        .waddr (wr_ptr_q),
        .wdata (load_data),
        .raddr (pc),
        .rdata (ram_rdata)
    );

`ifdef CALC_PROG_CHECKSUM_EN
    logic [IW-1:0] prog_sum_q, prog_sum_d;

    // Running XOR of accepted words, updated alongside the RAM write.
    always_comb begin
        prog_sum_d = prog_sum_q;
        if (load_start) begin
            prog_sum_d = '0;
        end else if (accept) begin
            prog_sum_d = prog_sum_q ^ load_data;
        end
    end

    // Checksum register.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            prog_sum_q <= '0;
        end else begin
            prog_sum_q <= prog_sum_d;
        end
    end

    assign prog_sum = prog_sum_q;
`endif

    assign load_ready = (state_q == LOAD);
    assign run        = (state_q == RUN);
    assign prog_len   = prog_len_q;
    assign load_err   = load_err_q;
    assign inst_w     = fetch_ok_q ? ram_rdata : NOP_WORD;

endmodule : calc_prog_store
`default_nettype wire

// File: tb/tb_calc_prog_store.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_calc_prog_store                                           |
// | Description : Self-checking bench for calc_prog_store. Fetch expectations  |
// |               are queued by the driver and popped by a monitor one cycle   |
// |               later; status outputs are compared directly.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_calc_prog_store;

    logic        CLOCK_50 = 1'b0;
    logic        reset_n  = 1'b0;
    logic        load_start = 1'b0;
    logic        load_valid = 1'b0;
    logic [10:0] load_data  = '0;
    logic        load_last  = 1'b0;
    logic [3:0]  pc         = '0;
    wire         load_ready;
    wire  [10:0] inst_w;
    wire         run;
    wire  [4:0]  prog_len;
    wire         load_err;
`ifdef CALC_PROG_CHECKSUM_EN
    wire  [10:0] prog_sum;
`endif

    int checks   = 0;
    int failures = 0;

    logic        fetch_req = 1'b0;
    logic [10:0] exp_q [$];

    calc_prog_store dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .load_start (load_start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .pc         (pc),
        .inst_w     (inst_w),
        .run        (run),
        .prog_len   (prog_len),
`ifdef CALC_PROG_CHECKSUM_EN
        .prog_sum   (prog_sum),
`endif
        .load_err   (load_err)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic fetch(input logic [3:0] a, input logic [10:0] exp);
        pc        = a;
        fetch_req = 1'b1;
        exp_q.push_back(exp);
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic send_word(input logic [10:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // Start pulse with a fetch of pc=0 on the same edge: must come back NOP.
    task automatic start_load();
        load_start = 1'b1;
        fetch(4'd0, 11'h000);
        load_start = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    // Monitor: any edge that sampled a fetch request owes one inst_w compare.
    initial begin
        logic        take;
        logic [10:0] exp;
        forever begin
            @(posedge CLOCK_50);
            take = fetch_req;
            @(negedge CLOCK_50);
            if (take) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL fetch_underflow: got 0x%0h with no expectation queued", inst_w);
                end else begin
                    exp = exp_q.pop_front();
                    chk("inst_w", {21'd0, inst_w}, {21'd0, exp});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        reset_n = 1'b1;

        // Reset state and a full pc sweep returning NOP.
        chk("rst_run", {31'd0, run}, 32'd0);
        chk("rst_ready", {31'd0, load_ready}, 32'd0);
        chk("rst_len", {27'd0, prog_len}, 32'd0);
        chk("rst_err", {31'd0, load_err}, 32'd0);
        chk("rst_inst", {21'd0, inst_w}, 32'h000);
        for (int i = 0; i < 16; i++) begin
            fetch(4'(i), 11'h000);
        end
        chk("idle_run", {31'd0, run}, 32'd0);

        // Three-word program terminated by load_last.
        start_load();
        chk("load_ready", {31'd0, load_ready}, 32'd1);
        chk("load_run", {31'd0, run}, 32'd0);
        send_word(11'h101, 1'b0);
        send_word(11'h202, 1'b0);
        chk("mid_run", {31'd0, run}, 32'd0);
        send_word(11'h303, 1'b1);
        chk("p3_run", {31'd0, run}, 32'd1);
        chk("p3_len", {27'd0, prog_len}, 32'd3);
        chk("p3_ready", {31'd0, load_ready}, 32'd0);
        fetch(4'd0, 11'h101);
        fetch(4'd1, 11'h202);
        fetch(4'd2, 11'h303);
        fetch(4'd3, 11'h000);
        fetch(4'd15, 11'h000);

        // Sixteen words without load_last; RUN entered on the 16th.
        start_load();
        chk("p16_run0", {31'd0, run}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            send_word(11'h010 + 11'(i), 1'b0);
            if (i == 14) chk("p16_run_15th", {31'd0, run}, 32'd0);
        end
        chk("p16_run", {31'd0, run}, 32'd1);
        chk("p16_len", {27'd0, prog_len}, 32'd16);
        fetch(4'd15, 11'h01F);
        fetch(4'd0, 11'h010);
        fetch(4'd7, 11'h017);

        // Stray word in RUN: dropped, error set, memory untouched.
        send_word(11'h7FF, 1'b0);
        chk("err_set", {31'd0, load_err}, 32'd1);
        chk("err_run", {31'd0, run}, 32'd1);
        chk("err_len", {27'd0, prog_len}, 32'd16);
        fetch(4'd0, 11'h010);

        // Partial load then reset: program invisible, error cleared by reset.
        start_load();
        chk("err_sticky", {31'd0, load_err}, 32'd1);
        send_word(11'h111, 1'b0);
        send_word(11'h222, 1'b0);
        chk("part_len", {27'd0, prog_len}, 32'd2);
        do_reset();
        chk("abort_run", {31'd0, run}, 32'd0);
        chk("abort_ready", {31'd0, load_ready}, 32'd0);
        chk("abort_len", {27'd0, prog_len}, 32'd0);
        chk("abort_err", {31'd0, load_err}, 32'd0);
        chk("abort_inst", {21'd0, inst_w}, 32'h000);
        fetch(4'd0, 11'h000);

        // Start and valid on the same edge: start wins, no word, no error.
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 11'h555;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        chk("same_len", {27'd0, prog_len}, 32'd0);
        chk("same_ready", {31'd0, load_ready}, 32'd1);
        chk("same_err", {31'd0, load_err}, 32'd0);
        send_word(11'h0F0, 1'b0);
        send_word(11'h00F, 1'b1);
        chk("cs_len", {27'd0, prog_len}, 32'd2);
`ifdef CALC_PROG_CHECKSUM_EN
        chk("prog_sum", {21'd0, prog_sum}, 32'h0FF);
`endif
        fetch(4'd0, 11'h0F0);
        fetch(4'd1, 11'h00F);
        fetch(4'd2, 11'h000);

        // Stray word in IDLE also sets the error.
        do_reset();
        send_word(11'h123, 1'b0);
        chk("idle_err", {31'd0, load_err}, 32'd1);
        chk("idle_len", {27'd0, prog_len}, 32'd0);

        tick();
        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_calc_prog_store
`default_nettype wire

// File: doc/calc_prog_store.md
# calc_prog_store

Program store and instruction feeder for the calculator core: the write/serving end of the calculator's `pc` → `inst_w` fetch interface. Programs are loaded one 11-bit word at a time over a valid/ready port into a 16-entry RAM. In RUN the block answers the calculator's 4-bit `pc` with the registered instruction word one cycle later. It replaces the fixed instruction ROM on the board top level.

## Interface
Parameters:
- `DEPTH`, 16: program words stored.
- `AW`, 4: address width; must equal `pc` width.
- `IW`, 11: instruction width; must equal `inst_w` width.
- `NOP_WORD`, 11'h000: word returned for unprogrammed or out-of-range addresses.

Ports:
- `CLOCK_50`, in, 1: sole clock; all logic on the rising edge.
- `reset_n`, in, 1: synchronous, active-low reset.
- `load_start`, in, 1: single-cycle pulse; begins a new program load.
- `load_valid`, in, 1: `load_data` holds a word to write.
- `load_data`, in, IW: program word.
- `load_last`, in, 1: qualifies the word with `load_valid`; marks the final word.
- `load_ready`, out, 1: block accepts a word this cycle.
- `pc`, in, AW: fetch address from the calculator.
- `inst_w`, out, IW: registered instruction for the calculator.
- `run`, out, 1: program valid; the calculator may execute.
- `prog_len`, out, AW+1: number of words loaded (0..16).
- `load_err`, out, 1: sticky; a word was offered while not loading.

## Operation
- States: IDLE, LOAD, RUN.
- IDLE: entered at reset. `load_ready`=0, `run`=0. Goes to LOAD on `load_start`.
- LOAD: `load_ready`=1. A word is accepted when `load_valid && load_ready`. It is written at `wr_ptr`; then `wr_ptr` and `prog_len` increment. The block goes to RUN on an accepted word with `load_last`=1, or on acceptance of the 16th word even if `load_last`=0.
- RUN: `run`=1. Goes to LOAD on `load_start`.
- `load_start` in any state clears `wr_ptr` and `prog_len` to 0 and enters LOAD. RAM contents are not cleared; `prog_len` masks stale words.
- `load_start` and `load_valid` in the same cycle: start wins, the word is discarded, `load_err` is unaffected.
- `load_valid` in IDLE or RUN: the word is dropped and `load_err` sets. `load_err` clears only on reset.
- Fetch: `inst_w` ← `mem[pc]` when state is RUN and `pc` < `prog_len`; otherwise `inst_w` ← `NOP_WORD`.
- The `pc` wrap from 15 to 0 needs no special handling.

## Timing
- Reset values: state IDLE, `inst_w`=`NOP_WORD`, `run`=0, `load_ready`=0, `prog_len`=0, `load_err`=0, `wr_ptr`=0.
- Fetch latency is exactly 1 cycle: the `pc` presented at edge N gives `inst_w` valid after edge N+1. A new `pc` can be issued every cycle.
- The word accepted at edge N is readable by a `pc` presented at edge N+1 or later.
- `run` rises on the edge that accepts the last word. It falls on the edge that samples `load_start`.
- From that `load_start` edge onward, `inst_w` returns `NOP_WORD` until RUN is re-entered.
- A reset asserted mid-load aborts the load. State goes to IDLE and the partially loaded program is invisible.

## Configuration
- `CALC_PROG_CHECKSUM_EN` defined:
  - adds output `prog_sum` (IW bits), the running XOR of all accepted words;
  - `prog_sum` resets to 0 and clears on `load_start`;
  - it updates on the same edge as the RAM write.
- `CALC_PROG_CHECKSUM_EN` undefined: no port and no logic.

## Structure
- Shared package `calc_pkg` holds:
  - `CALC_IW`=11, `CALC_AW`=4, `CALC_DEPTH`=16;
  - `CALC_NOP`=11'h000;
  - the state enum `prog_state_t` {IDLE, LOAD, RUN}.
- One sub-module, `calc_prog_ram`: DEPTH×IW memory with synchronous write and synchronous read, mapping to M10K. The NOP masking mux sits after it, using `run` and a registered `pc < prog_len` compare.

## Test plan
- After reset, sweep `pc`=0..15 → `inst_w`=11'h000 every cycle; `run`=0, `load_ready`=0.
- `load_start`, then words 11'h101, 11'h202, 11'h303 with `load_last` on the third → `run`=1 and `prog_len`=3. Then `pc`=0,1,2,3 → `inst_w`=11'h101, 11'h202, 11'h303, 11'h000, each one cycle after its `pc`.
- Load 16 words 11'h010+i with `load_last`=0 throughout → RUN is entered on the 16th word. `pc`=15 → 11'h01F; wrapping to `pc`=0 → 11'h010.
- In RUN, pulse `load_valid` with 11'h7FF → `load_err`=1, memory unchanged, `pc`=0 still returns the old word. `load_err` stays 1 until reset.
- Mid-load, with 2 words accepted, assert `reset_n`=0 for one cycle → IDLE, `prog_len`=0, `inst_w`=11'h000. Same-cycle `load_start`+`load_valid` → `prog_len`=0.
- With `CALC_PROG_CHECKSUM_EN` defined, load 11'h0F0 and 11'h00F → `prog_sum`=11'h0FF.
